regfile_mp: RTL and testbench

Parametrised multi-port register file: successor to the single-write, two-read MIPS register file. It generalises data width, register count and read-port count, and keeps a dedicated link-write port for jump-and-link. It adds write-to-read bypass, read enables, and a sequential bulk-clear engine with a busy handshake. It sits in the decode stage, feeding operand registers and accepting writeback from the WB stage.

---
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with link port, bulk clear engine and optional REGFILE_BYPASS_EN write-to-read bypass
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int LINK_REG = NUM_REGS - 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     clr_req,
  output logic                     clr_busy
);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d, rd_src;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
  logic busy, wr_ok, link_ok;
  assign busy = state_q == CLEAR;
  assign clr_busy = busy;
  assign rd_data = rd_data_q;
`ifdef REGFILE_BYPASS_EN
  assign rd_src = regs_d;
`else
  assign rd_src = regs_q;
`endif
  // clear engine: walks clr_idx through every register once, ignoring requests while running
  always_comb begin
    state_d = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == IDLE) begin
      if (clr_req) begin
        state_d = CLEAR;
        clr_idx_d = '0;
      end
    end else begin
      clr_idx_d = clr_idx_q + 1'b1;
      state_d = clr_idx_q == LAST_A ? IDLE : CLEAR;
    end
  end
  // next array contents: link write applied last so it wins on LINK_REG, clear overrides everything
  always_comb begin
    wr_ok = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
    link_ok = link_en && !busy && !(ZERO_REG != 0 && LINK_A == '0);
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
    if (link_ok) regs_d[LINK_A] = link_data;
    if (busy) regs_d[clr_idx_q] = '0;
  end
  // read lanes: hold when disabled, zero during clear or for the hardwired zero register
  always_comb begin
    rd_data_d = rd_data_q;
    for (int p = 0; p < NUM_RD; p++)
      if (rd_en[p])
        rd_data_d[p] = (busy || (ZERO_REG != 0 && rd_addr[p*ADDR_W +: ADDR_W] == '0)) ? '0
                     : rd_src[rd_addr[p*ADDR_W +: ADDR_W]];
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_idx_q <= '0;
      regs_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      regs_q <= regs_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table, random and corner-case checks of regfile_mp against a reference model
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic [1:0] rd_en = 0;
  logic [9:0] rd_addr = 0;
  logic [63:0] rd_data;
  logic wr_en = 0, link_en = 0, clr_req = 0, clr_busy;
  logic [4:0] wr_addr = 0;
  logic [31:0] wr_data = 0, link_data = 0;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mem [32];
  logic [31:0] lane_m [2];
  int clear_left = 0;

  regfile_mp dut (.clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en), .link_data(link_data),
    .clr_req(clr_req), .clr_busy(clr_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic le; logic [31:0] ld;
    logic [1:0] re; logic [4:0] ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 0;
    lane_m[0] = 0;
    lane_m[1] = 0;
    clear_left = 0;
  endtask

  // spec-level model: clear_left counts remaining clear cycles, register index = 32 - clear_left
  task automatic model_edge();
    logic [31:0] nm [32];
    logic [4:0] a;
    bit busy;
    busy = clear_left > 0;
    nm = mem;
    if (!busy) begin
      if (wr_en && wr_addr != 0) nm[wr_addr] = wr_data;
      if (link_en) nm[31] = link_data;
    end else nm[32 - clear_left] = 0;
    for (int p = 0; p < 2; p++)
      if (rd_en[p]) begin
        a = rd_addr[p*5 +: 5];
        lane_m[p] = (busy || a == 0) ? 32'h0 : (BYP ? nm[a] : mem[a]);
      end
    if (busy) clear_left--;
    else if (clr_req) clear_left = 32;
    mem = nm;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic le,
                       input logic [31:0] ld, input logic [1:0] re, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd; link_en = le; link_data = ld;
    rd_en = re; rd_addr = {ra1, ra0}; clr_req = cr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("lane0_model", rd_data[31:0], lane_m[0]);
    check("lane1_model", rd_data[63:32], lane_m[1]);
    check("busy_model", {31'b0, clr_busy}, {31'b0, clear_left > 0});
  endtask

  vec_t tbl [8];
  int cnt;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 2'b11, 5, 31, 0, 0};
    tbl[1] = '{1, 7, 32'hDEADBEEF, 0, 0, 2'b00, 7, 7, 0, 0};
    tbl[2] = '{1, 0, 32'h1234, 0, 0, 2'b11, 7, 0, 32'hDEADBEEF, 0};
    tbl[3] = '{1, 31, 32'hAAAA0000, 1, 32'h00400010, 2'b11, 0, 7, 0, 32'hDEADBEEF};
    tbl[4] = '{0, 0, 0, 0, 0, 2'b11, 31, 31, 32'h00400010, 32'h00400010};
    tbl[5] = '{0, 0, 0, 0, 0, 2'b10, 3, 7, 32'h00400010, 32'hDEADBEEF};
    tbl[6] = '{1, 9, 32'hCAFEF00D, 0, 0, 2'b11, 9, 31, BYP ? 32'hCAFEF00D : 32'h0, 32'h00400010};
    tbl[7] = '{0, 0, 0, 0, 0, 2'b11, 9, 0, 32'hCAFEF00D, 0};
    model_reset();
    #3;
    check("reset_busy", {31'b0, clr_busy}, 0);
    check("reset_data", rd_data[31:0] | rd_data[63:32], 0);
    #9 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].le, tbl[i].ld, tbl[i].re, tbl[i].ra0, tbl[i].ra1, 0);
      step();
      check($sformatf("tbl%0d_lane0", i), rd_data[31:0], tbl[i].e0);
      check($sformatf("tbl%0d_lane1", i), rd_data[63:32], tbl[i].e1);
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0, 5'($urandom), $urandom, $urandom_range(0, 5) == 0, $urandom,
            2'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 60) == 0);
      step();
    end
    for (int i = 0; i < 40 && clr_busy; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    for (int r = 1; r < 32; r++) begin
      drive(1, 5'(r), 32'h1000 + r, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check("clear_start", {31'b0, clr_busy}, 1);
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      drive(1, 5'($urandom_range(1, 31)), $urandom | 1, 1, 32'h77, 2'b11, 5'($urandom_range(1, 31)), 31, 1);
      step();
      check("busy_read", rd_data[31:0] | rd_data[63:32], 0);
      cnt++;
    end
    check("clear_len", cnt, 32);
    for (int r = 0; r < 32; r += 2) begin
      drive(0, 0, 0, 0, 0, 2'b11, 5'(r), 5'(r + 1), 0);
      step();
      check("post_clear", rd_data[31:0] | rd_data[63:32], 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    check("midclear_busy", {31'b0, clr_busy}, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("abort_busy", {31'b0, clr_busy}, 0);
    check("abort_data", rd_data[31:0] | rd_data[63:32], 0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(1, 3, 32'h55, 0, 0, 0, 0, 0, 0);
    step();
    check("after_abort_busy", {31'b0, clr_busy}, 0);
    drive(0, 0, 0, 0, 0, 2'b01, 3, 0, 0);
    step();
    check("after_abort_r3", rd_data[31:0], 32'h55);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
